bl_zone_sched: RTL
==================

BL_ZONE_SCHED -- requirements
Module: bl_zone_sched

Interface
REQ-001 SHALL have these ports; clock and reset come first:
- iODCK, in, 1: pixel clock; all logic is on its rising edge.
- iRST, in, 1: synchronous, active-high reset.
- iDE, in, 1: active-video data enable.
- iVS, in, 1: one-cycle frame-start pulse.
- iDutySW, in, 2: PWM period select.
- iWr_En, in, 1: duty write request.
- iWr_Zone, in, 5: target zone, 0..23.
- iWr_Duty, in, 7: duty in lines.
- oWr_Rdy, out, 1: write accepted this cycle.
- oH_Count, out, 12: pixel index in the active line.
- oZone, out, 5: current zone, 0..23; 24 means out of range.
- oLine_Phase, out, 7: PWM line phase.
- oH_Duty, out, 24: one-hot zone-on vector.
- oFrame_Err, out, 1: sticky line-overrun flag.

REQ-002 SHALL have one parameter: ZONE_W, default 80, the number of pixels per zone.

Function
REQ-003 SHALL set PWM period P = 64 when iDutySW==2'b01, else P = 80; P is sampled every cycle.
REQ-004 SHALL increment oH_Count by 1 each cycle iDE=1, and SHALL clear it to 0 on the first cycle iDE=0.
REQ-005 SHALL track the zone with a pixel-in-zone counter (0..ZONE_W-1) plus a zone counter; no divider. Both clear when iDE=0.
REQ-006 SHALL advance the zone counter when the pixel-in-zone counter wraps.
REQ-007 SHALL saturate oZone at 24 when the active line exceeds 24*ZONE_W pixels (1920). At the same point oFrame_Err SHALL set and stay set until iRST.
REQ-008 SHALL increment oLine_Phase once per iDE falling edge (line end), wrapping from P-1 to 0.
REQ-009 SHALL clear oLine_Phase to 0 when iVS=1, taking priority over the increment.
REQ-010 SHALL wrap oLine_Phase to 0 on the next line end if P shrinks while oLine_Phase ≥ P.
REQ-011 SHALL hold a 24x7 shadow duty bank (write side) and a 24x7 active duty bank (compare side).
REQ-012 SHALL drive oWr_Rdy = !iVS && !iRST. A write is accepted on a cycle where iWr_En && oWr_Rdy.
REQ-013 SHALL, on an accepted write, store min(iWr_Duty, 80) into shadow[iWr_Zone].
REQ-014 SHALL ignore writes with iWr_Zone>23, leaving the bank unchanged; oWr_Rdy still reads 1.
REQ-015 SHALL copy the whole shadow bank to the active bank in the cycle iVS=1. A requester whose write coincides with iVS holds iWr_En and completes on the next cycle.
REQ-016 SHALL register oH_Duty with one cycle of latency from the (iDE, zone) pixel state.
REQ-017 SHALL set bit[z] of oH_Duty = (oLine_Phase < active[z]) when iDE=1 and zone z<24; all other bits are 0. Result: duty 0 is never on, and duty ≥ P is always on.
REQ-018 SHALL force oH_Duty to 24'h0 whenever iDE=0 or the zone is 24.
REQ-019 SHALL apply the same rules to iVS arriving mid-line: the phase clears, banks swap, and the H/zone counters are unaffected.

Reset
REQ-020 SHALL, while iRST=1 on a clock edge, clear the following to 0: oH_Count, oZone, oLine_Phase, oH_Duty, oFrame_Err, the pixel-in-zone counter, and both duty banks.
REQ-021 SHALL hold oWr_Rdy at 0 while iRST=1 and drop any write presented during reset.
REQ-022 SHALL let iRST asserted mid-line abort the line. After release, counting restarts at 0 on the next iDE=1 cycle.

Configuration
REQ-023 SHALL provide readback controlled by macro BL_DUTY_READBACK_EN.
- Defined: adds output oRd_Duty[6:0] = registered active[iWr_Zone], with one-cycle latency; it reads 0 when iWr_Zone>23 and 0 in reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-024 SHALL cover these directed scenarios:
- Scan: after reset, write duty 40 to zones 0..23, pulse iVS, run 1920-pixel lines with iDutySW=01. oH_Duty is one-hot per 80-pixel zone, 1 cycle late, on for phases 0..39 and 0 for 40..63; oLine_Phase wraps 63→0.
- Extremes: zone 5 duty 0 and zone 6 duty 100 (stored as 80), with iDutySW=00. Bit5 is never set; bit6 is set on every line.
- Bank swap: write zone 3 duty 10 mid-frame. Output is unchanged until iVS; from the first line after iVS, bit3 follows duty 10.
- Write/iVS collision: iWr_En held across an iVS cycle. oWr_Rdy=0 during iVS, the write lands the next cycle, and the active bank keeps its old value for zone 3.
- Overrun: a 2000-pixel active line. oZone=24 from pixel 1920, oH_Duty=0 there, oFrame_Err=1 and sticky; iRST clears everything.
- Bad zone and readback: a write to zone 30 changes nothing. With BL_DUTY_READBACK_EN, oRd_Duty tracks the active value of iWr_Zone.

Source files
------------

// File: rtl/bl_zone_sched.sv
// Backlight zone scheduler: per-zone line-PWM with shadow/active duty banks.
// Optional registered duty readback port enabled by `define BL_DUTY_READBACK_EN.
module bl_zone_sched #(
    parameter int ZONE_W = 80
) (
    input  logic        iODCK,
    input  logic        iRST,
    input  logic        iDE,
    input  logic        iVS,
    input  logic [1:0]  iDutySW,
    input  logic        iWr_En,
    input  logic [4:0]  iWr_Zone,
    input  logic [6:0]  iWr_Duty,
    output logic        oWr_Rdy,
    output logic [11:0] oH_Count,
    output logic [4:0]  oZone,
    output logic [6:0]  oLine_Phase,
    output logic [23:0] oH_Duty,
`ifdef BL_DUTY_READBACK_EN
    output logic        oFrame_Err,
    output logic [6:0]  oRd_Duty
`else
    output logic        oFrame_Err
`endif
);

    localparam int NZ = 24;
    localparam int PW = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(ZONE_W - 1);
    localparam logic [4:0] ZONE_OOR = 5'd24;

    logic [PW-1:0] pix_cnt;
    logic          de_q;
    logic          line_end;
    logic          wr_acc;
    logic [6:0]    period;
    logic [6:0]    duty_sat;
    logic [23:0]   zone_oh;
    logic [23:0]   duty_on;
    logic [6:0]    shadow [NZ];
    logic [6:0]    active [NZ];

    always_comb begin
        period   = (iDutySW == 2'b01) ? 7'd64 : 7'd80;
        oWr_Rdy  = !iVS && !iRST;
        wr_acc   = iWr_En && oWr_Rdy;
        duty_sat = (iWr_Duty > 7'd80) ? 7'd80 : iWr_Duty;
        line_end = de_q && !iDE;
        zone_oh  = '0;
        duty_on  = '0;
        for (int z = 0; z < NZ; z++) begin
            zone_oh[z] = (oZone == 5'(z));
            duty_on[z] = (oLine_Phase < active[z]);
        end
    end

    // Zone tracking: pixel-in-zone counter carries into the zone counter,
    // which parks at 24 once the line runs past the last zone.
    always_ff @(posedge iODCK) begin
        if (iRST) begin
            oH_Count   <= '0;
            pix_cnt    <= '0;
            oZone      <= '0;
            oFrame_Err <= 1'b0;
            de_q       <= 1'b0;
        end else begin
            de_q <= iDE;
            if (iDE) begin
                oH_Count <= oH_Count + 12'd1;
                if (oZone == ZONE_OOR) begin
                    oFrame_Err <= 1'b1;
                end
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt <= '0;
                    if (oZone != ZONE_OOR) begin
                        oZone <= oZone + 5'd1;
                    end
                end else begin
                    pix_cnt <= pix_cnt + PW'(1);
                end
            end else begin
                oH_Count <= '0;
                pix_cnt  <= '0;
                oZone    <= '0;
            end
        end
    end

    // A phase left above a newly shrunk period wraps at the next line end.
    always_ff @(posedge iODCK) begin
        if (iRST) begin
            oLine_Phase <= '0;
        end else if (iVS) begin
            oLine_Phase <= '0;
        end else if (line_end) begin
            if (oLine_Phase >= period - 7'd1) begin
                oLine_Phase <= '0;
            end else begin
                oLine_Phase <= oLine_Phase + 7'd1;
            end
        end
    end

    always_ff @(posedge iODCK) begin
        if (iRST) begin
            for (int z = 0; z < NZ; z++) begin
                shadow[z] <= '0;
                active[z] <= '0;
            end
        end else begin
            for (int z = 0; z < NZ; z++) begin
                if (wr_acc && iWr_Zone == 5'(z)) begin
                    shadow[z] <= duty_sat;
                end
            end
            if (iVS) begin
                for (int z = 0; z < NZ; z++) begin
                    active[z] <= shadow[z];
                end
            end
        end
    end

    always_ff @(posedge iODCK) begin
        if (iRST) begin
            oH_Duty <= '0;
        end else if (iDE) begin
            oH_Duty <= zone_oh & duty_on;
        end else begin
            oH_Duty <= '0;
        end
    end

`ifdef BL_DUTY_READBACK_EN
    logic [6:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        for (int z = 0; z < NZ; z++) begin
            if (iWr_Zone == 5'(z)) begin
                rd_sel = active[z];
            end
        end
    end

    always_ff @(posedge iODCK) begin
        if (iRST) begin
            oRd_Duty <= '0;
        end else begin
            oRd_Duty <= rd_sel;
        end
    end
`endif

endmodule
